// File: rtl/seq_divider_32.sv
// Multi-cycle 32-bit restoring divider, one quotient bit per cycle, signed/unsigned.
// Start/busy/done handshake; results and div_by_zero are held until the next result.
module seq_divider_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_q;
  logic [32:0] r_pr;
  logic [31:0] r_dvs;
  logic [4:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;
  logic        r_dbz;

  logic        w_accept;
  logic        w_dd_neg;
  logic        w_dv_neg;
  logic [31:0] w_dd_mag;
  logic [31:0] w_dv_mag;
  logic [32:0] w_shifted;
  logic [32:0] w_trial;

  // A new request is only taken when no division is in flight.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_dd_neg = is_signed & dividend[31];
  assign w_dv_neg = is_signed & divisor[31];
  assign w_dd_mag = w_dd_neg ? (32'd0 - dividend) : dividend;
  assign w_dv_mag = w_dv_neg ? (32'd0 - divisor)  : divisor;

  // Partial remainder stays below the divisor, so bit 32 of the trial is its sign.
  assign w_shifted = {r_pr[31:0], r_q[31]};
  assign w_trial   = w_shifted - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (divisor == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == 5'd0) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (w_accept) begin
          w_state_next = (divisor == 32'd0) ? S_DONE : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= 32'd0;
      r_pr        <= 33'd0;
      r_dvs       <= 32'd0;
      r_cnt       <= 5'd0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
      r_dbz       <= 1'b0;
    end else begin
      if (w_accept) begin
        if (divisor == 32'd0) begin
          r_quotient  <= 32'hFFFF_FFFF;
          r_remainder <= dividend;
          r_dbz       <= 1'b1;
        end else begin
          r_q     <= w_dd_mag;
          r_dvs   <= w_dv_mag;
          r_pr    <= 33'd0;
          r_cnt   <= 5'd31;
          r_neg_q <= w_dd_neg ^ w_dv_neg;
          r_neg_r <= w_dd_neg;
        end
      end else if (r_state == S_RUN) begin
        if (!w_trial[32]) begin
          r_pr <= w_trial;
          r_q  <= {r_q[30:0], 1'b1};
        end else begin
          r_pr <= w_shifted;
          r_q  <= {r_q[30:0], 1'b0};
        end
        r_cnt <= r_cnt - 5'd1;
      end else if (r_state == S_FIX) begin
        r_quotient  <= r_neg_q ? (32'd0 - r_q) : r_q;
        r_remainder <= r_neg_r ? (32'd0 - r_pr[31:0]) : r_pr[31:0];
        r_dbz       <= 1'b0;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed self-checking bench for seq_divider_32: latency, busy window, signed/unsigned
// results, divide-by-zero, ignored start while busy, back-to-back and mid-operation reset.
module tb_seq_divider_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_32 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Drives start for exactly one sampling edge; returns #1 after that edge (cycle 1).
  task automatic start_op(input logic sgn, input logic [31:0] dd, input logic [31:0] dv);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = dd;
    divisor   = dv;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = $urandom_range(0, 1);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Watches cycles 1.. until done; optionally pulses a 9/3 start at cycle inj.
  task automatic wait_done(input string tag, input int exp_lat, input int inj);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (inj != 0 && k == inj) begin
        start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
      end
      if (inj != 0 && k == inj + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt, (exp_lat > 1) ? exp_lat - 1 : 0);
  endtask

  task automatic chk_res(input string tag, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] dd,
                     input logic [31:0] dv, input int lat, input logic [31:0] eq,
                     input logic [31:0] er, input logic edbz);
    start_op(sgn, dd, dv);
    wait_done(tag, lat, 0);
    chk_res(tag, eq, er, edbz);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_res("rst", 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run("u100_7",   1'b0, 32'd100,        32'd7,        34, 32'd14,        32'd2,        1'b0);
    run("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,        34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("u-7_2",    1'b0, 32'hFFFF_FFF9,  32'd2,        34, 32'h7FFF_FFFC, 32'd1,        1'b0);
    run("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1,        1'b0);
    run("s-7_-2",   1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 34, 32'd3,         32'hFFFF_FFFF, 1'b0);
    run("dbz",      1'b0, 32'h1234_5678,  32'd0,        1,  32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run("smin_-1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0,        1'b0);
    run("u_max_big",1'b0, 32'hFFFF_FFFF,  32'h8000_0000, 34, 32'd1,         32'h7FFF_FFFF, 1'b0);

    // Start while busy is ignored; then back-to-back start in the DONE cycle.
    start_op(1'b0, 32'd50, 32'd5);
    wait_done("ign", 34, 10);
    chk_res("ign", 32'd10, 32'd0, 1'b0);
    start_op(1'b0, 32'd9, 32'd3);
    chk("b2b_hold_q", quotient, 32'd10);
    wait_done("b2b", 34, 0);
    chk_res("b2b", 32'd3, 32'd0, 1'b0);
    @(negedge clk);

    // Reset in cycle 15 of a division.
    start_op(1'b0, 32'd1000, 32'd3);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 15) rst = 1'b1;
    end
    @(negedge clk);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk_res("mrst", 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mrst_no_done", done_cnt, 32'd0);
    run("u81_9", 1'b0, 32'd81, 32'd9, 34, 32'd9, 32'd0, 1'b0);

    // Reset and start in the same cycle: start dropped.
    rst = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 32'd20; divisor = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_done", {31'd0, done}, 32'd0);
    chk("rst_start_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_start_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
